// File: rtl/arb_pkg.sv
// Shared types and helpers for the two-requester memory port arbiter.
package arb_pkg;

  // Arbiter ownership states: nobody, instruction fetch, or load/store
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Requester indices on the shared port
  localparam int REQ_IFETCH = 0;
  localparam int REQ_LDST   = 1;

  // Round-robin choice between two requesters.
  // Returns {valid, index}; on a tie the requester that did not own last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic valid;
    logic idx;
    valid = |req;
    if (req == 2'b11) begin
      idx = ~last;
    end else if (req[1]) begin
      idx = 1'b1;
    end else begin
      idx = 1'b0;
    end
    return {valid, idx};
  endfunction

endpackage

// File: rtl/mem_port_arb2_hold_timer.sv
// Watchdog hold counter: counts cycles a grant is held and flags the last
// allowed cycle. With TIMEOUT=0 the counter stays at zero and never expires.
module hold_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  // Count held cycles, restart on every grant entry, saturate at TIMEOUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (int'(count) < TIMEOUT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (TIMEOUT > 0) && (int'(count) == TIMEOUT - 1);

endmodule

// File: rtl/mem_port_arb2.sv
// Round-robin arbiter with transaction lock sharing one memory port between
// instruction fetch (requester 0) and load/store (requester 1).
module mem_port_arb2
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       done,
  output logic [1:0] grant,
  output logic       sel,
  output logic       busy,
  output logic       timeout_err
);

  state_t     state;
  state_t     state_next;
  logic       last;
  logic       owner;
  logic       rel_now;
  logic       wd_expire;
  logic       timer_expire;
  logic       timer_clear;
  logic       timer_en;
  logic [1:0] pick;

  assign owner = (state == OWN1);

  // The timer restarts whenever nobody owns the port or ownership is released
  assign timer_clear = (state == IDLE) | rel_now;
  assign timer_en    = ~timer_clear;

  hold_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: arbitrate when idle or on release; done beats the watchdog
  always_comb begin
    wd_expire  = (state != IDLE) & timer_expire & ~done & req[owner];
    rel_now    = (state != IDLE) & (done | ~req[owner] | wd_expire);
    pick       = rr_pick(req, (state == IDLE) ? last : owner);
    state_next = state;
    if ((state == IDLE) || rel_now) begin
      if (pick[1]) begin
        state_next = pick[0] ? OWN1 : OWN0;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Registered side outputs: mux select moves only with a new grant,
  // round-robin history updates on release, error pulses after expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= 1'b0;
      last        <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expire;
      if (rel_now) begin
        last <= owner;
      end
      if (state_next != IDLE) begin
        sel <= (state_next == OWN1);
      end
    end
  end

  // Output decode from the state register
  always_comb begin
    grant             = 2'b00;
    grant[REQ_IFETCH] = (state == OWN0);
    grant[REQ_LDST]   = (state == OWN1);
    busy              = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arb2.sv
// Directed self-checking bench for mem_port_arb2 (TIMEOUT=4 and TIMEOUT=0).
module tb_mem_port_arb2;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic       done;
  logic [1:0] grant;
  logic       sel;
  logic       busy;
  logic       timeout_err;
  logic [1:0] grant0;
  logic       sel0;
  logic       busy0;
  logic       timeout_err0;

  int checkCount = 0;
  int errorCount = 0;

  mem_port_arb2 #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .sel         (sel),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  mem_port_arb2 #(.TIMEOUT(0)) dut0 (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant0),
    .sel         (sel0),
    .busy        (busy0),
    .timeout_err (timeout_err0)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Both instances must never grant to two requesters at once
  always @(negedge clk) begin
    assert (grant != 2'b11) else $error("[TB] FAIL grant_onehot grant=%b", grant);
    assert (grant0 != 2'b11) else $error("[TB] FAIL grant0_onehot grant=%b", grant0);
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] g, input logic s, input logic b, input logic e);
    checkOutput({tag, "_grant"}, {6'd0, grant}, {6'd0, g});
    checkOutput({tag, "_sel"}, {7'd0, sel}, {7'd0, s});
    checkOutput({tag, "_busy"}, {7'd0, busy}, {7'd0, b});
    checkOutput({tag, "_terr"}, {7'd0, timeout_err}, {7'd0, e});
  endtask

  // Drive one cycle of inputs, then move to just after the next rising edge
  task automatic applyStimulus(input logic [1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    done  = 1'b0;

    // Reset held three cycles, then idle with no requests
    repeat (3) begin
      @(posedge clk);
      #1;
      checkAll("in_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 1'b0);
      checkAll("idle", 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // Simple grant to load/store, then done with requests gone
    applyStimulus(2'b10, 1'b0);
    checkAll("grant1", 2'b10, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'b10, 1'b0);
    checkAll("grant1_hold", 2'b10, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b1);
    checkAll("done_to_idle", 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0);
    checkAll("idle_sel_kept", 2'b00, 1'b1, 1'b0, 1'b0);

    // Mid-cycle reset clears outputs before the next clock edge
    applyStimulus(2'b01, 1'b0);
    checkAll("grant0", 2'b01, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkAll("async_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Tie right after reset goes to requester 0
    applyStimulus(2'b11, 1'b0);
    checkAll("tie_first", 2'b01, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b0);
    checkAll("tie_hold", 2'b01, 1'b0, 1'b1, 1'b0);

    // Round robin with both requesting and done every second cycle
    for (int k = 0; k < 4; k++) begin
      logic expOwner;
      expOwner = (k % 2 == 0);
      applyStimulus(2'b11, 1'b1);
      checkAll("rr_handoff", expOwner ? 2'b10 : 2'b01, expOwner, 1'b1, 1'b0);
      applyStimulus(2'b11, 1'b0);
      checkAll("rr_hold", expOwner ? 2'b10 : 2'b01, expOwner, 1'b1, 1'b0);
    end
    applyStimulus(2'b00, 1'b1);
    checkAll("rr_end", 2'b00, 1'b0, 1'b0, 1'b0);

    // Dropping req acts as release and hands off immediately
    applyStimulus(2'b01, 1'b0);
    checkAll("drop_own0", 2'b01, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b0);
    checkAll("drop_hold", 2'b01, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b10, 1'b0);
    checkAll("drop_handoff", 2'b10, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0);
    checkAll("drop_idle", 2'b00, 1'b1, 1'b0, 1'b0);

    // Watchdog: four held cycles, then error pulse and re-grant
    applyStimulus(2'b01, 1'b0);
    checkAll("wd_c0", 2'b01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b0);
      checkAll("wd_held", 2'b01, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(2'b01, 1'b0);
    checkAll("wd_expire_regrant", 2'b01, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b0);
      checkAll("wd_restart", 2'b01, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(2'b11, 1'b0);
    checkAll("wd_expire_handoff", 2'b10, 1'b1, 1'b1, 1'b1);

    // Done on the last allowed cycle wins over the watchdog
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b10, 1'b0);
      checkAll("wd1_held", 2'b10, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(2'b10, 1'b1);
    checkAll("wd_done_wins", 2'b10, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'b10, 1'b0);
    checkAll("wd_done_after", 2'b10, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0);
    checkAll("wd_idle", 2'b00, 1'b1, 1'b0, 1'b0);

    // TIMEOUT=0 instance holds the grant indefinitely
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0);
    reset = 1'b0;
    applyStimulus(2'b01, 1'b0);
    checkOutput("nowd_grant", {6'd0, grant0}, 8'h01);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(2'b01, 1'b0);
      checkOutput("nowd_hold", {6'd0, grant0}, 8'h01);
      checkOutput("nowd_terr", {7'd0, timeout_err0}, 8'h00);
    end
    checkOutput("nowd_busy", {7'd0, busy0}, 8'h01);
    checkOutput("nowd_sel", {7'd0, sel0}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arb2.md
Name: mem_port_arb2

Overview:
- Two-requester round-robin arbiter with transaction lock.
- Shares one WIDTH-wide resource, such as the data-memory port, between instruction fetch (requester 0) and load/store (requester 1).
- Drives the select of the 2:1 datapath mux in front of the resource.
- Issues one-hot grants to the requesters and holds ownership until the owner finishes or a watchdog expires.

Parameters:
- TIMEOUT, 16, maximum cycles a grant may be held without release; 0 disables the watchdog.
- CW, $clog2(TIMEOUT+1), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  2  req[i] high = requester i wants the resource; level, held until granted
- done  input  1  resource finished the current transaction; valid only while a grant is active
- grant  output  2  one-hot or zero, registered; grant[i] = requester i owns the resource
- sel  output  1  registered mux select; equals index of current or most recent owner
- busy  output  1  registered; high while any grant is active
- timeout_err  output  1  registered one-cycle pulse when the watchdog forces release

Behaviour:
- Reset values: grant=2'b00, sel=0, busy=0, timeout_err=0, last=1, hold count=0, state=IDLE.
  - last=1 means requester 0 wins the first tie.
- States: IDLE, OWN0, OWN1. grant = {state==OWN1, state==OWN0}; busy = (state!=IDLE).
- Arbitration function, evaluated in IDLE or on a release cycle:
  - If only one req is high, pick it.
  - If both are high, pick the index != last.
  - If none are high, go to IDLE.
- IDLE to OWNi:
  - Request sampled at edge N; grant[i]=1 and sel=i from edge N+1.
  - Latency: 1 cycle from req to grant.
- Release condition in OWNi: done | ~req[i] | watchdog_expire.
  - A requester dropping req is treated as done.
- On a release cycle:
  - last<=i.
  - The next owner is chosen by the arbitration function using req sampled that same cycle, with i excluded if its req is low.
  - Back-to-back hand-off OWN0 to OWN1 occurs in one edge, with no IDLE bubble.
  - OWNi to OWNi directly is allowed only when the other req is low and req[i] stays high. The hold counter restarts at 0.
- sel changes only on the edge that asserts a new grant. In IDLE, sel holds the last owner, so the mux output stays stable.
- Watchdog (TIMEOUT>0):
  - Hold counter is cleared on every grant entry and increments each cycle in OWNx without release.
  - watchdog_expire = (count == TIMEOUT-1) & ~done & req[owner].
  - On expiry: timeout_err=1 for exactly the next cycle, and release is processed as above.
  - done on the expiry cycle takes precedence, so no error is flagged.
  - The counter saturates and never wraps.
- TIMEOUT=0: the counter is held at 0, timeout_err is never asserted, and the grant is held indefinitely.
- done while IDLE is ignored.
- Invariant: grant is never 2'b11.
- reset asserted mid-transaction: all outputs go to reset values immediately, without waiting for a clock. After reset deasserts, the first grant follows normal 1-cycle latency.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, OWN0, OWN1};
  - localparams REQ_IFETCH=0 and REQ_LDST=1;
  - a function rr_pick(req, last) returning {valid, index}.
- One sub-module, hold_timer:
  - parameter TIMEOUT;
  - inputs clk, reset, clear, en;
  - output expire.
  - The arbiter FSM instantiates hold_timer; the next-state and output registers stay in the top module.

Test Plan:
- Reset/idle: hold reset 3 cycles, then drive req=00 for 5 cycles -> grant=00, sel=0, busy=0, timeout_err=0 throughout. Asserting reset mid-cycle clears grant before the next clk edge.
- Simple grant: req=10 at edge 1 -> grant=10, sel=1, busy=1 from edge 2. done pulse at edge 4 with req=00 -> grant=00 at edge 5; sel stays 1.
- Tie and round robin:
  - After reset, req=11 -> grant=01 first.
  - With req held 11 and done pulsed every 2nd cycle -> grant alternates 01,10,01,10 with no IDLE cycle between owners, and sel toggles on each hand-off.
- Req drop as release: owner 0 granted, req goes 11 to 10 with no done -> next edge grant=10, sel=1.
- Watchdog:
  - TIMEOUT=4, req=01 held, no done -> grant=01 for exactly 4 cycles, then timeout_err=1 for 1 cycle.
  - With req still 01 and the other req low -> re-grant 01 with the counter restarted.
  - With req=11 -> grant=10 instead.
  - done on the 4th held cycle -> no timeout_err.
- TIMEOUT=0: grant held 100 cycles without done -> grant unchanged, timeout_err stays 0. Also check grant never equals 11 (assertion).
